// File: rtl/hazard_ctrl.sv
// Hazard, stall and flush control for the 5-stage pipeline.
// Define HAZARD_FORWARDING_EN to enable ALU operand forwarding.
module hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             jump_id,
    input  logic [REG_W-1:0] rs_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic [REG_W-1:0] wreg_ex,
    input  logic             regwrite_ex,
    input  logic             memread_ex,
    input  logic [REG_W-1:0] wreg_mem,
    input  logic             regwrite_mem,
    input  logic             branch_taken_mem,
    input  logic [REG_W-1:0] wreg_wb,
    input  logic             regwrite_wb,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_t;

    state_t state;
    state_t state_nx;

    function automatic logic hit(
        input logic             use_src,
        input logic             rw,
        input logic [REG_W-1:0] wreg,
        input logic [REG_W-1:0] src
    );
        return use_src && rw && (wreg != '0) && (wreg == src);
    endfunction

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic haz_lu;
    logic haz_raw;
    logic stall;
    logic jump_flush;
    logic any_flush;
    logic stall_cnt_en;

    assign ex_hit  = hit(use_rs_id, regwrite_ex, wreg_ex, rs_id)
                   | hit(use_rt_id, regwrite_ex, wreg_ex, rt_id);
    assign mem_hit = hit(use_rs_id, regwrite_mem, wreg_mem, rs_id)
                   | hit(use_rt_id, regwrite_mem, wreg_mem, rt_id);
    assign wb_hit  = hit(use_rs_id, regwrite_wb, wreg_wb, rs_id)
                   | hit(use_rt_id, regwrite_wb, wreg_wb, rt_id);

    assign haz_lu = ex_hit && memread_ex;

`ifdef HAZARD_FORWARDING_EN
    logic unused_hits;
    assign unused_hits = mem_hit ^ wb_hit;
    assign haz_raw = 1'b0;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (hit(1'b1, regwrite_mem, wreg_mem, src))
            return 2'b10;
        else if (hit(1'b1, regwrite_wb, wreg_wb, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;
    assign fwd_a_c = fwd_sel(rs_ex);
    assign fwd_b_c = fwd_sel(rt_ex);
`else
    // No write-through in the register bank, so WB must also stall.
    logic unused_fwd;
    assign unused_fwd = ^{rs_ex, rt_ex};
    assign haz_raw = ex_hit | mem_hit | wb_hit;

    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;
    assign fwd_a_c = 2'b00;
    assign fwd_b_c = 2'b00;
`endif

    assign stall        = haz_lu | haz_raw;
    assign jump_flush   = jump_id && !stall && !branch_taken_mem;
    assign any_flush    = branch_taken_mem | jump_flush;
    assign stall_cnt_en = stall && !branch_taken_mem;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        fwd_a        = fwd_a_c;
        fwd_b        = fwd_b_c;
        state_nx     = RUN;
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
        end else if (branch_taken_mem) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            state_nx     = FLUSH;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_nx     = STALL;
        end else if (jump_id) begin
            if_id_flush  = 1'b1;
            state_nx     = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            busy      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != RUN);
            if (stall_cnt_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (any_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// A second instance with CNT_W = 2 covers counter saturation.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex;
    logic [4:0] wreg_ex, wreg_mem, wreg_wb;
    logic       use_rs_id, use_rt_id, jump_id;
    logic       regwrite_ex, memread_ex, regwrite_mem;
    logic       branch_taken_mem, regwrite_wb;

    logic        pc_write, if_id_write, if_id_flush;
    logic        id_ex_bubble, ex_mem_flush, busy;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_if_id_write, s_if_id_flush;
    logic        s_id_ex_bubble, s_ex_mem_flush, s_busy;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(32), .REG_W(5)) u_dut (
        .clk(clk), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .jump_id(jump_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex),
        .wreg_ex(wreg_ex), .regwrite_ex(regwrite_ex),
        .memread_ex(memread_ex),
        .wreg_mem(wreg_mem), .regwrite_mem(regwrite_mem),
        .branch_taken_mem(branch_taken_mem),
        .wreg_wb(wreg_wb), .regwrite_wb(regwrite_wb),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_mem_flush(ex_mem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .busy(busy)
    );

    hazard_ctrl #(.CNT_W(2), .REG_W(5)) u_sat (
        .clk(clk), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .jump_id(jump_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex),
        .wreg_ex(wreg_ex), .regwrite_ex(regwrite_ex),
        .memread_ex(memread_ex),
        .wreg_mem(wreg_mem), .regwrite_mem(regwrite_mem),
        .branch_taken_mem(branch_taken_mem),
        .wreg_wb(wreg_wb), .regwrite_wb(regwrite_wb),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
        .ex_mem_flush(s_ex_mem_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
        .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
        jump_id = 0; rs_ex = 0; rt_ex = 0;
        wreg_ex = 0; regwrite_ex = 0; memread_ex = 0;
        wreg_mem = 0; regwrite_mem = 0; branch_taken_mem = 0;
        wreg_wb = 0; regwrite_wb = 0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #2;
        check("rst_pc_write", pc_write, 0);
        check("rst_if_id_write", if_id_write, 0);
        check("rst_if_id_flush", if_id_flush, 1);
        check("rst_bubble", id_ex_bubble, 1);
        check("rst_ex_mem_flush", ex_mem_flush, 1);
        check("rst_busy", busy, 0);
        check("rst_fwd_a", fwd_a, 0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("rel_pc_write", pc_write, 1);
        check("rel_if_id_write", if_id_write, 1);
        check("rel_if_id_flush", if_id_flush, 0);
        check("rel_stall_cnt", stall_cnt, 0);
        check("rel_flush_cnt", flush_cnt, 0);
        tick();
        check("rel_busy", busy, 0);

        // $0 never matches; unused sources never match
        regwrite_ex = 1; memread_ex = 1; wreg_ex = 0;
        rs_id = 0; use_rs_id = 1;
        #1 check("r0_no_stall", pc_write, 1);
        wreg_ex = 3; rs_id = 3; use_rs_id = 0;
        #1 check("nouse_no_stall", pc_write, 1);
        tick();
        idle();

`ifdef HAZARD_FORWARDING_EN
        // lw $2 in EX, add reading $2 in ID
        wreg_ex = 2; regwrite_ex = 1; memread_ex = 1;
        rt_id = 2; use_rt_id = 1;
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_bubble", id_ex_bubble, 1);
        tick(); exp_stall++;
        idle();
        rt_id = 2; use_rt_id = 1;
        wreg_mem = 2; regwrite_mem = 1;
        #1 check("lu_resume", pc_write, 1);
        check("lu_stall_cnt", stall_cnt, exp_stall);
        tick();
        idle();
        rt_ex = 2; wreg_wb = 2; regwrite_wb = 1;
        #1 check("lu_fwd_b", fwd_b, 2'b01);
        check("lu_fwd_a", fwd_a, 2'b00);
        tick();
        idle();
`else
        // add $3 in EX, sub reading $3 in ID
        rs_id = 3; use_rs_id = 1;
        wreg_ex = 3; regwrite_ex = 1;
        #1;
        check("raw1_pc_write", pc_write, 0);
        check("raw1_if_id_write", if_id_write, 0);
        check("raw1_bubble", id_ex_bubble, 1);
        tick(); exp_stall++;
        check("raw_busy", busy, 1);
        regwrite_ex = 0; wreg_ex = 0;
        wreg_mem = 3; regwrite_mem = 1;
        #1 check("raw2_pc_write", pc_write, 0);
        tick(); exp_stall++;
        regwrite_mem = 0; wreg_mem = 0;
        wreg_wb = 3; regwrite_wb = 1;
        #1 check("raw3_pc_write", pc_write, 0);
        tick(); exp_stall++;
        regwrite_wb = 0; wreg_wb = 0;
        #1 check("raw4_pc_write", pc_write, 1);
        check("raw_stall_cnt", stall_cnt, exp_stall);
        tick();
        check("raw_busy_done", busy, 0);
        idle();
`endif

        // forwarding selects; ID reads nothing so no stall
        rs_ex = 5; rt_ex = 5;
        wreg_mem = 5; regwrite_mem = 1;
        wreg_wb = 5; regwrite_wb = 1;
`ifdef HAZARD_FORWARDING_EN
        #1 check("fwd_mem_prio", fwd_a, 2'b10);
        regwrite_mem = 0;
        #1 check("fwd_wb", fwd_a, 2'b01);
        check("fwd_b_wb", fwd_b, 2'b01);
        rs_ex = 0; wreg_mem = 0; wreg_wb = 0;
        regwrite_mem = 1;
        #1 check("fwd_r0", fwd_a, 2'b00);
`else
        #1 check("fwd_a_tied", fwd_a, 2'b00);
        check("fwd_b_tied", fwd_b, 2'b00);
`endif
        idle();

        // branch wins over a load-use hazard
        wreg_ex = 2; regwrite_ex = 1; memread_ex = 1;
        rs_id = 2; use_rs_id = 1;
        branch_taken_mem = 1;
        #1;
        check("br_pc_write", pc_write, 1);
        check("br_if_id_flush", if_id_flush, 1);
        check("br_bubble", id_ex_bubble, 1);
        check("br_ex_mem_flush", ex_mem_flush, 1);
        tick(); exp_flush++;
        check("br_stall_cnt", stall_cnt, exp_stall);
        check("br_flush_cnt", flush_cnt, exp_flush);
        check("br_busy", busy, 1);
        idle();

        // jump squashes the fall-through fetch
        jump_id = 1;
        #1;
        check("j_if_id_flush", if_id_flush, 1);
        check("j_pc_write", pc_write, 1);
        check("j_bubble", id_ex_bubble, 0);
        tick(); exp_flush++;
        jump_id = 0;
        #1;
        check("j_flush_off", if_id_flush, 0);
        check("j_busy", busy, 1);
        check("j_flush_cnt", flush_cnt, exp_flush);
        tick();
        check("j_busy_done", busy, 0);

        // stall beats jump
        jump_id = 1;
        wreg_ex = 4; regwrite_ex = 1; memread_ex = 1;
        rs_id = 4; use_rs_id = 1;
        #1;
        check("js_if_id_flush", if_id_flush, 0);
        check("js_pc_write", pc_write, 0);
        tick(); exp_stall++;
        check("js_flush_cnt", flush_cnt, exp_flush);
        check("js_stall_cnt", stall_cnt, exp_stall);
        check("js_busy", busy, 1);

        // reset mid-stall abandons it
        reset = 1'b0;
        #1;
        check("mr_pc_write", pc_write, 0);
        check("mr_if_id_flush", if_id_flush, 1);
        check("mr_busy", busy, 0);
        check("mr_stall_cnt", stall_cnt, 0);
        idle();
        tick();
        reset = 1'b1;
        exp_flush = 0;

        // five jump flushes saturate a 2-bit counter
        jump_id = 1;
        repeat (5) tick();
        jump_id = 0;
        #1;
        check("sat_flush_cnt", s_flush_cnt, 3);
        check("wide_flush_cnt", flush_cnt, 5);
        check("sat_stall_cnt", s_stall_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got %0d, expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
